// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   ld_op_t : load-operation encoding carried from MEM into WB
//   GPR_W   : general-purpose register index width
package cpu_pkg;

  localparam int GPR_W = 5;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5,
    LD_LWL  = 3'd6,
    LD_LWR  = 3'd7
  } ld_op_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake and payload bundle.
//   master : MEM side, drives valid + payload, observes ws_allowin
//   slave  : WB side, observes valid + payload, drives ws_allowin
interface wb_stage_if import cpu_pkg::*; #(
  parameter int PC_W = 32
);
  logic              ms_to_ws_valid;
  logic [PC_W-1:0]   ms_pc;
  logic              ms_gr_we;
  logic [GPR_W-1:0]  ms_dest;
  ld_op_t            ms_ld_op;
  logic [31:0]       ms_alu_result;
  logic [31:0]       ms_ld_rdata;
  logic [31:0]       ms_rt_old;
  logic              ws_allowin;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_ld_op,
           ms_alu_result, ms_ld_rdata, ms_rt_old,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_ld_op,
           ms_alu_result, ms_ld_rdata, ms_rt_old,
    output ws_allowin
  );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load extraction / merge.
//   ld_op  : load operation
//   off    : byte offset (address bits [1:0])
//   alu    : ALU result, passed through for non-loads
//   m      : raw aligned word from data RAM
//   r      : old rt value, merged by LWL/LWR
//   result : value to write back
module wb_load_align import cpu_pkg::*; (
  input  ld_op_t      ld_op,
  input  logic [1:0]  off,
  input  logic [31:0] alu,
  input  logic [31:0] m,
  input  logic [31:0] r,
  output logic [31:0] result
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = m[7:0];
    case (off)
      2'd0: ld_byte = m[7:0];
      2'd1: ld_byte = m[15:8];
      2'd2: ld_byte = m[23:16];
      2'd3: ld_byte = m[31:24];
      default: ld_byte = m[7:0];
    endcase
    // halfword alignment is not trapped here; off[0] is simply ignored
    ld_half = off[1] ? m[31:16] : m[15:0];
  end

  always_comb begin
    result = alu;
    case (ld_op)
      LD_NONE: result = alu;
      LD_LB:   result = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  result = {24'd0, ld_byte};
      LD_LH:   result = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  result = {16'd0, ld_half};
      LD_LW:   result = m;
      LD_LWL: begin
        case (off)
          2'd0: result = {m[7:0],  r[23:0]};
          2'd1: result = {m[15:0], r[15:0]};
          2'd2: result = {m[23:0], r[7:0]};
          default: result = m;
        endcase
      end
      LD_LWR: begin
        case (off)
          2'd0: result = m;
          2'd1: result = {r[31:24], m[31:8]};
          2'd2: result = {r[31:16], m[31:16]};
          default: result = {r[31:8], m[31:24]};
        endcase
      end
      default: result = alu;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage.
//   clk, rst           : clock, async active-high reset
//   ms                 : MEM->WB handshake + payload (slave side)
//   ws_stall           : external hold
//   rf_wen/waddr/wdata : register-file write port
//   ws_fwd_*           : forwarding tap to ID (valid is independent of stall)
//   debug_wb_*         : trace port
module wb_stage import cpu_pkg::*; #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  wb_stage_if.slave           ms,
  input  logic                ws_stall,
  output logic                rf_wen,
  output logic [GPR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                ws_fwd_valid,
  output logic [GPR_W-1:0]    ws_fwd_dest,
  output logic [DATA_W-1:0]   ws_fwd_data,
  output logic [PC_W-1:0]     debug_wb_pc,
  output logic [3:0]          debug_wb_rf_wen
);

  logic              ws_valid;
  logic [PC_W-1:0]   ws_pc;
  logic              ws_gr_we;
  logic [GPR_W-1:0]  ws_dest;
  ld_op_t            ws_ld_op;
  logic [DATA_W-1:0] ws_alu_result;
  logic [DATA_W-1:0] ws_ld_rdata;
  logic [DATA_W-1:0] ws_rt_old;
  logic [DATA_W-1:0] final_result;
  logic              ws_ready_go;
  logic              ws_writes;

  assign ws_ready_go   = !ws_stall;
  assign ms.ws_allowin = !ws_valid || ws_ready_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_valid <= 1'b0;
    end else if (ms.ws_allowin) begin
      ws_valid <= ms.ms_to_ws_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_pc         <= '0;
      ws_gr_we      <= 1'b0;
      ws_dest       <= '0;
      ws_ld_op      <= LD_NONE;
      ws_alu_result <= '0;
      ws_ld_rdata   <= '0;
      ws_rt_old     <= '0;
    end else if (ms.ws_allowin && ms.ms_to_ws_valid) begin
      ws_pc         <= ms.ms_pc;
      ws_gr_we      <= ms.ms_gr_we;
      ws_dest       <= ms.ms_dest;
      ws_ld_op      <= ms.ms_ld_op;
      ws_alu_result <= ms.ms_alu_result;
      ws_ld_rdata   <= ms.ms_ld_rdata;
      ws_rt_old     <= ms.ms_rt_old;
    end
  end

  wb_load_align u_align (
    .ld_op  (ws_ld_op),
    .off    (ws_alu_result[1:0]),
    .alu    (ws_alu_result),
    .m      (ws_ld_rdata),
    .r      (ws_rt_old),
    .result (final_result)
  );

  // $zero is never written and never forwarded
  assign ws_writes       = ws_valid && ws_gr_we && (ws_dest != '0);
  assign rf_wen          = ws_writes && ws_ready_go;
  assign rf_waddr        = ws_dest;
  assign rf_wdata        = final_result;
  assign ws_fwd_valid    = ws_writes;
  assign ws_fwd_dest     = ws_dest;
  assign ws_fwd_data     = final_result;
  assign debug_wb_pc     = ws_pc;
  assign debug_wb_rf_wen = {4{rf_wen}};

endmodule
